// File: rtl/seg_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_frame_decoder_if
//   Bundles the symbol stream and decoded results of seg_frame_decoder.
//   master : symbol source / result consumer (drives seg_in, seg_valid)
//   slave  : the decoder (drives p_out, q_out, frame_valid, frame_err, busy)
//   seg_in      [6:0]          segment pattern, bit6=g .. bit0=a
//   seg_valid                  one symbol per high cycle
//   p_out/q_out [4*NDIGITS-1:0] last good P / Q words
//   frame_valid                one-cycle pulse, p_out/q_out just updated
//   frame_err                  one-cycle pulse, malformed frame discarded
//   busy                       frame in progress
// ---------------------------------------------------------------------------
interface seg_frame_decoder_if #(
    parameter int NDIGITS = 4
);
    logic [6:0]           seg_in;
    logic                 seg_valid;
    logic [4*NDIGITS-1:0] p_out;
    logic [4*NDIGITS-1:0] q_out;
    logic                 frame_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output seg_in, seg_valid,
        input  p_out, q_out, frame_valid, frame_err, busy
    );

    modport slave (
        input  seg_in, seg_valid,
        output p_out, q_out, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/seg_frame_decoder.sv
// ---------------------------------------------------------------------------
// seg_frame_decoder
//   Receives seven-segment glyphs and reassembles frames of the form
//   P_MARK, NDIGITS hex digits (MS first), Q_MARK, NDIGITS hex digits.
//   Good frames update p_out/q_out together with a frame_valid pulse;
//   malformed frames are dropped with a frame_err pulse.
//   Ports: clk, rst_n (async, active-low), bus (seg_frame_decoder_if.slave).
// ---------------------------------------------------------------------------
module seg_frame_decoder #(
    parameter int         NDIGITS = 4,
    parameter logic [6:0] P_MARK  = 7'b1110011,
    parameter logic [6:0] Q_MARK  = 7'b1100111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_frame_decoder_if.slave   bus
);
    localparam int W  = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    // Glyph for nibble value i sits at index i.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111011, 7'b1110001
    };

    typedef enum logic [1:0] {IDLE, P_DIG, WAIT_Q, Q_DIG} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  shp_q, shq_q;
    logic [W-1:0]  p_q, q_q;
    logic          fv_q, fe_q;

    // ---- glyph decode: one exact comparator per table entry ----
    logic [15:0] hit;
    logic        dig_ok;
    logic [3:0]  dig_nib;
    logic        is_p, is_q;
    logic        bad_sym;

    for (genvar gi = 0; gi < 16; gi++) begin : g_glyph
        assign hit[gi] = (bus.seg_in == GLYPH[gi]);
    end

    assign is_p = (bus.seg_in == P_MARK);
    assign is_q = (bus.seg_in == Q_MARK);

    always_comb begin
        dig_ok  = |hit;
        dig_nib = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) dig_nib = 4'(i);
        end
    end

    // A symbol that does not fit the current frame position. IDLE never
    // complains: anything other than P_MARK there is just line noise.
    always_comb begin
        bad_sym = 1'b0;
        case (state_q)
            P_DIG, Q_DIG: bad_sym = !dig_ok;
            WAIT_Q:       bad_sym = !is_q;
            default:      bad_sym = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shp_q   <= '0;
            shq_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            fe_q <= 1'b0;
            if (bus.seg_valid) begin
                if (bad_sym) begin
                    // Drop the partial frame. A P_MARK is itself a valid frame
                    // start, so it is consumed as such rather than lost.
                    fe_q    <= 1'b1;
                    shp_q   <= '0;
                    shq_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= is_p ? P_DIG : IDLE;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (is_p) begin
                                state_q <= P_DIG;
                                cnt_q   <= '0;
                                shp_q   <= '0;
                            end
                        end
                        P_DIG: begin
                            shp_q <= (shp_q << 4) | W'(dig_nib);
                            if (cnt_q == LAST) begin
                                cnt_q   <= '0;
                                state_q <= WAIT_Q;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        WAIT_Q: begin
                            state_q <= Q_DIG;
                            cnt_q   <= '0;
                            shq_q   <= '0;
                        end
                        Q_DIG: begin
                            shq_q <= (shq_q << 4) | W'(dig_nib);
                            if (cnt_q == LAST) begin
                                // Publish both words at once so p_out/q_out
                                // never expose a half-updated pair.
                                p_q     <= shp_q;
                                q_q     <= (shq_q << 4) | W'(dig_nib);
                                fv_q    <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= IDLE;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.p_out       = p_q;
    assign bus.q_out       = q_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
